// File: rtl/ksa.sv
// RC4 key-scheduling stage: permutes the 256-byte S-memory left by the init stage
// using a 24-bit key, one swap per six cycles over a shared single-port RAM.
module ksa (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  addr,
    input  logic [7:0]  rddata,
    output logic [7:0]  wrdata,
    output logic        wren
);

    typedef enum logic [2:0] {
        IDLE,
        READ_I,
        LATCH_I,
        READ_J,
        LATCH_J,
        WRITE_I,
        WRITE_J
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  i;
    logic [7:0]  j;
    logic [7:0]  si;
    logic [7:0]  sj;
    logic [23:0] key_q;
    logic [1:0]  ksel;
    logic [7:0]  kbyte;

    // ksel tracks i mod 3 incrementally so no divider is needed.
    always_comb begin
        case (ksel)
            2'd0:    kbyte = key_q[23:16];
            2'd1:    kbyte = key_q[15:8];
            default: kbyte = key_q[7:0];
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Reset wins over every state, so an in-flight swap is abandoned cleanly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i     <= 8'd0;
            j     <= 8'd0;
            si    <= 8'd0;
            sj    <= 8'd0;
            key_q <= 24'd0;
            ksel  <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        key_q <= key;
                        i     <= 8'd0;
                        j     <= 8'd0;
                        ksel  <= 2'd0;
                    end
                end
                LATCH_I: begin
                    si <= rddata;
                    j  <= j + rddata + kbyte;
                end
                LATCH_J: begin
                    sj <= rddata;
                end
                WRITE_J: begin
                    if (i != 8'hFF) begin
                        i <= i + 8'd1;
                    end
                    ksel <= (ksel == 2'd2) ? 2'd0 : ksel + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // NOTE: every output and the next state get a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        rdy        = 1'b0;
        addr       = 8'd0;
        wrdata     = 8'd0;
        wren       = 1'b0;
        case (state)
            IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    state_next = READ_I;
                end
            end
            READ_I: begin
                addr       = i;
                state_next = LATCH_I;
            end
            LATCH_I: begin
                state_next = READ_J;
            end
            READ_J: begin
                addr       = j;
                state_next = LATCH_J;
            end
            LATCH_J: begin
                state_next = WRITE_I;
            end
            WRITE_I: begin
                addr       = i;
                wrdata     = sj;
                wren       = 1'b1;
                state_next = WRITE_J;
            end
            WRITE_J: begin
                // When i == j both writes hit one address with the same byte.
                addr       = j;
                wrdata     = si;
                wren       = 1'b1;
                state_next = (i == 8'hFF) ? IDLE : READ_I;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
